bist_lfsr_tpg: RTL and testbench

//   BIST stimulus source for small gate-level CUTs such as a 3-input AND cell.
//   On start, it loads an 8-bit LFSR from a seed and emits N pseudo-random patterns
//   on pat[2:0], which drives the CUT inputs i0..i2. It then raises done.
//   It sits directly upstream of the CUT. The optional MISR compacts the CUT output o.

---
 rtl/bist_lfsr_tpg_pkg.sv | 21 ++
 rtl/bist_lfsr_tpg_if.sv | 15 +
 rtl/bist_lfsr_tpg_misr.sv | 27 ++
 rtl/bist_lfsr_tpg.sv | 98 +++++++++
 tb/tb_bist_lfsr_tpg.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bist_lfsr_tpg_pkg.sv
// Shared types and constants for the LFSR-based BIST pattern generator.
// Holds the FSM state enum and the shift/feedback step used by both the LFSR and the MISR.
package bist_lfsr_tpg_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1, maximal length
   localparam int PAT_W = 3;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & TAPS)};
   endfunction

endpackage

// File: rtl/bist_lfsr_tpg_if.sv
// Pattern stream between the generator and the circuit under test, plus the CUT response.
interface bist_lfsr_tpg_if;
   import bist_lfsr_tpg_pkg::*;

   // pat is transferred on a cycle where pat_valid && pat_ready; while pat_valid is high and
   // pat_ready is low, pat holds. cut_o is the combinational CUT answer to the current pat.
   logic [PAT_W-1:0] pat;
   logic             pat_valid;
   logic             pat_ready;
   logic             cut_o;

   modport master (output pat, output pat_valid, input pat_ready, input cut_o);
   modport slave  (input pat, input pat_valid, output pat_ready, output cut_o);

endinterface

// File: rtl/bist_lfsr_tpg_misr.sv
// Single-input MISR compacting the CUT response on every accepted pattern.
module bist_misr
   import bist_lfsr_tpg_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              accept,
   input  logic              cut_o,
   output logic [LFSR_W-1:0] signature
);

   logic [LFSR_W-1:0] misr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         misr <= '0;
      end else if (clear) begin
         misr <= '0;
      end else if (accept) begin
         misr <= lfsr_next(misr) ^ {{(LFSR_W-1){1'b0}}, cut_o};
      end
   end

   assign signature = misr;

endmodule

// File: rtl/bist_lfsr_tpg.sv
// BIST test-pattern generator: seeds an 8-bit LFSR and streams N patterns to a small CUT.
// Optional response compaction is built when the macro BIST_MISR_EN is defined.
module bist_lfsr_tpg
   import bist_lfsr_tpg_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LFSR_W-1:0] seed,
   input  logic [CNT_W-1:0]  num_patterns,
   bist_lfsr_tpg_if.master   tpg,
   output logic              busy,
   output logic              done,
   output logic [LFSR_W-1:0] signature,
   output state_t            state_dbg
);

   state_t            state;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_nxt;
   logic [LFSR_W-1:0] seed_eff;
   logic [CNT_W-1:0]  cnt;
   logic              accept;

   // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
   assign seed_eff  = (seed == '0) ? LFSR_W'(1) : seed;
   assign lfsr_nxt  = lfsr_next(lfsr);
   assign accept    = (state == RUN) && tpg.pat_ready;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         lfsr          <= '0;
         cnt           <= '0;
         tpg.pat       <= '0;
         tpg.pat_valid <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               lfsr <= seed_eff;
               cnt  <= num_patterns;
               if (num_patterns == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state         <= RUN;
                  tpg.pat       <= seed_eff[PAT_W-1:0];
                  tpg.pat_valid <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  lfsr    <= lfsr_nxt;
                  cnt     <= cnt - 1'b1;
                  tpg.pat <= lfsr_nxt[PAT_W-1:0];
                  if (cnt == CNT_W'(1)) begin
                     state         <= DONE;
                     tpg.pat_valid <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BIST_MISR_EN
   bist_misr u_misr (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (state == LOAD),
      .accept    (accept),
      .cut_o     (tpg.cut_o),
      .signature (signature)
   );
`else
   logic unused_cut_o;
   assign unused_cut_o = tpg.cut_o;
   assign signature    = '0;
`endif

endmodule

// File: tb/tb_bist_lfsr_tpg.sv
// Directed scoreboard bench for bist_lfsr_tpg: expected patterns and signatures are queued
// by the driver tasks and consumed by a monitor that watches accepts and done pulses.
module tb_bist_lfsr_tpg;
   import bist_lfsr_tpg_pkg::*;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [LFSR_W-1:0] seed;
   logic [CNT_W-1:0]  num_patterns;
   logic              busy;
   logic              done;
   logic [LFSR_W-1:0] signature;
   state_t            state_dbg;

   bist_lfsr_tpg_if tpg ();

   bist_lfsr_tpg dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .seed         (seed),
      .num_patterns (num_patterns),
      .tpg          (tpg),
      .busy         (busy),
      .done         (done),
      .signature    (signature),
      .state_dbg    (state_dbg)
   );

`ifdef BIST_MISR_EN
   localparam logic [LFSR_W-1:0] SIG_T6 = 8'h03;
`else
   localparam logic [LFSR_W-1:0] SIG_T6 = 8'h00;
`endif

   logic [PAT_W-1:0]  exp_q[$];
   logic [LFSR_W-1:0] sig_q[$];
   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int stall_at = -1;
   int stall_cnt = 0;
   bit expect_done = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ready driver: optional 3-cycle stall armed by the monitor
   initial begin
      tpg.pat_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            tpg.pat_ready = 1'b0;
            stall_cnt--;
         end else begin
            tpg.pat_ready = 1'b1;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [PAT_W-1:0] e;
      if (reset_n) begin
         if (expect_done) begin
            check("done_after_last", {31'd0, done}, 32'd1);
            expect_done = 0;
         end
         if (tpg.pat_valid && tpg.pat_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_accept", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pat", {29'd0, tpg.pat}, {29'd0, e});
               acc_cnt++;
               if (exp_q.size() == 0) expect_done = 1;
               if (acc_cnt == stall_at) stall_cnt = 3;
            end
         end else if (tpg.pat_valid && exp_q.size() > 0) begin
            check("pat_hold", {29'd0, tpg.pat}, {29'd0, exp_q[0]});
         end
         if (done) begin
            done_cnt++;
            if (sig_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("signature", {24'd0, signature}, {24'd0, sig_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic launch(input logic [LFSR_W-1:0] s, input logic [CNT_W-1:0] n);
      @(posedge clk);
      #1;
      seed = s;
      num_patterns = n;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run(input logic [LFSR_W-1:0] s, input logic [CNT_W-1:0] n, input logic c,
                      input logic [LFSR_W-1:0] exp_sig, input int stall);
      int d0;
      int guard;
      acc_cnt = 0;
      stall_at = stall;
      tpg.cut_o = c;
      sig_q.push_back(exp_sig);
      d0 = done_cnt;
      launch(s, n);
      @(negedge clk);
      check("load_busy", {31'd0, busy}, 32'd1);
      check("load_no_valid", {31'd0, tpg.pat_valid}, 32'd0);
      @(negedge clk);
      check("first_valid", {31'd0, tpg.pat_valid}, {31'd0, n != 0});
      check("zero_n_done", {31'd0, done}, {31'd0, n == 0});
      guard = 0;
      while (done_cnt == d0 && guard < 300) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 300) check("done_timeout", 32'd0, 32'd1);
      check("accept_count", acc_cnt, {24'd0, n});
      check("queue_empty", exp_q.size(), 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("back_to_idle", {30'd0, state_dbg}, {30'd0, IDLE});
      check("sig_hold", {24'd0, signature}, {24'd0, exp_sig});
      stall_at = -1;
      tpg.cut_o = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pat"}, {29'd0, tpg.pat}, 32'd0);
      check({tag, "_valid"}, {31'd0, tpg.pat_valid}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_sig"}, {24'd0, signature}, 32'd0);
      check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, IDLE});
   endtask

   initial begin
      int d0;
      int guard;
      reset_n = 1'b0;
      start = 1'b0;
      seed = '0;
      num_patterns = '0;
      tpg.cut_o = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // seed 01, N=4: 001,010,100,000
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      exp_q.push_back(3'b100); exp_q.push_back(3'b000);
      run(8'h01, 8'd4, 1'b0, 8'h00, -1);

      // zero seed forced to 1
      exp_q.push_back(3'b001);
      run(8'h00, 8'd1, 1'b0, 8'h00, -1);

      // N=0: straight to done, no patterns
      run(8'h37, 8'd0, 1'b0, 8'h00, -1);

      // backpressure: 010 held for 3 cycles after the first accept
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      exp_q.push_back(3'b100); exp_q.push_back(3'b000);
      run(8'h01, 8'd4, 1'b0, 8'h00, 1);

      // reset during RUN: seed 5A gives 010,100,001,010
      exp_q.push_back(3'b010); exp_q.push_back(3'b100);
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      acc_cnt = 0;
      d0 = done_cnt;
      launch(8'h5A, 8'd10);
      guard = 0;
      while (acc_cnt < 3 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 100) check("abort_timeout", 32'd0, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      expect_done = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      check("no_done_after_abort", done_cnt, d0);

      // rerun from the same seed after the abort
      exp_q.push_back(3'b010); exp_q.push_back(3'b100);
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      run(8'h5A, 8'd4, 1'b0, 8'h00, -1);

      // response compaction with cut_o stuck at 1
      exp_q.push_back(3'b001); exp_q.push_back(3'b010);
      run(8'h01, 8'd2, 1'b1, SIG_T6, -1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
